bit_decision: RTL and testbench
===============================

# bit_decision

Bit-level decision and symbol-timing stage downstream of the reference and orthogonal correlators. It takes both signed 8-bit correlation results once per sample and forms a differential metric. It searches for the first threshold crossing, then tracks symbol timing with a per-symbol peak-search window and early/late correction. For each symbol it emits one decided data bit and a lock flag to the packet framer.

## Interface
- SYMBOL_LEN, 60, samples per bit (4 samples/chip × 15 chips); must be even, ≥ 8
- THRESH_MIN, 8'd20, minimum detection threshold on |metric|
- LOSS_LIMIT, 3, consecutive missed symbols that drop lock (1..7)
- clk_correlator  in  1  sample clock, shared with correlators, posedge
- rst_n  in  1  asynchronous, active-low reset
- corr_valid  in  1  ref_corr/orth_corr hold a new sample this cycle
- ref_corr  in  8 signed  reference-code correlation
- orth_corr  in  8 signed  orthogonal-code correlation
- bit_out  out  1  decided bit: 1 = reference won, 0 = orthogonal won
- bit_valid  out  1  one-cycle strobe qualifying bit_out
- locked  out  1  symbol timing acquired
- peak_mag  out  8  |metric| of the last decided symbol's peak

## Operation
- Metric: metric = ref_corr − orth_corr, 9-bit signed (−255..255). mag = |metric|, 8-bit unsigned, no saturation needed.
- HALF = SYMBOL_LEN/2. Phase counter ph runs 0..SYMBOL_LEN−1. It advances only on corr_valid.
- Reset state: all outputs 0, state SEARCH, ph 0, miss_cnt 0, thresh = THRESH_MIN.
- SEARCH: on a corr_valid sample with mag ≥ thresh, enter TRACK and assert locked.
  - The crossing sample seeds the window: win_max = mag, win_sign = metric ≥ 0, peak_idx = HALF, ph = HALF.
- TRACK, per corr_valid sample:
  - If mag > win_max (strictly greater, so the earliest sample wins ties), update win_max, win_sign and peak_idx = ph.
  - At ph == SYMBOL_LEN−1, evaluate the window.
- Window evaluation:
  - Hit (win_max ≥ thresh):
    - Pulse bit_valid with bit_out = win_sign and peak_mag = win_max.
    - Clear miss_cnt.
    - Apply timing correction:
      - peak_idx < HALF−1 (early): next ph = 1, so the next window is one sample shorter.
      - peak_idx > HALF+1 (late): ph holds at 0 for one extra sample, so the next window is one sample longer.
      - Otherwise: ph wraps to 0.
  - Miss: no bit_valid, miss_cnt++, ph wraps to 0, no timing correction. When miss_cnt reaches LOSS_LIMIT, go to SEARCH, drop locked and clear miss_cnt.
  - Either case: clear win_max and reset peak_idx to HALF for the next window.
- Threshold: see Configuration. Changes only at a hit evaluation or on reset.
- bit_out and peak_mag hold their values between strobes.

## Timing
- Registered outputs. bit_valid asserts the cycle after the clk_correlator edge that samples ph == SYMBOL_LEN−1 with corr_valid high. It is high for exactly one cycle.
- locked rises one cycle after the crossing sample. It falls one cycle after the evaluation that reaches LOSS_LIMIT.
- The first bit after acquisition is emitted at the end of the seeded window: SYMBOL_LEN−HALF samples after the crossing, counting the crossing sample itself.
- Gaps: when corr_valid is low, all state holds and no strobe is produced.
- Simultaneous events: a sample at ph == SYMBOL_LEN−1 updates win_max before the evaluation uses it.
- rst_n assertion mid-symbol clears state and outputs immediately; no partial bit is emitted. Release is synchronised externally.

## Configuration
- BIT_DECISION_ADAPTIVE_THRESH_EN defined: after each hit, thresh = max(THRESH_MIN, win_max >> 1). On a transition to SEARCH, thresh reverts to THRESH_MIN.
- Undefined: thresh is fixed at THRESH_MIN and the adaptive logic is removed.

## Test plan
- Reset with corr_valid = 1 and ref = orth = 0 for 200 samples → locked = 0, no bit_valid, all outputs 0.
- Idle, then a single sample ref = 40, orth = −10, then ideal peaks of metric +50 every 60 samples → locked rises next cycle; first bit_valid 30 samples later with bit_out = 1, peak_mag = 50; subsequent strobes every 60 samples with no correction.
- Locked stream, peaks drift to ph = 27 → next window is 59 samples. Peaks at ph = 33 → next window is 61 samples. Peaks at ph = 29..31 → window stays 60.
- Locked, with ref = −30 and orth = 30 at the peak → bit_out = 0, peak_mag = 60.
- Locked, then all-zero input → three windows without a strobe; locked falls after the third evaluation. A later crossing re-acquires.
- Locked with peaks of 100, macro defined → a later peak of 45 is a miss (thresh 50). The same bench without the macro → a strobe is produced. Asserting rst_n mid-window → outputs are 0 immediately.

Source files
------------

// File: rtl/bit_decision.sv
// bit_decision
//   Bit-level decision and symbol-timing stage. It forms metric = ref - orth
//   from the two correlators and acquires symbol timing on the first threshold
//   crossing. It then tracks timing with a per-symbol peak-search window and
//   early/late correction, and emits one decided bit per symbol.
//
//   Optional feature macro: BIT_DECISION_ADAPTIVE_THRESH_EN
//     defined   : after each hit, thresh = max(THRESH_MIN, peak >> 1);
//                 thresh reverts to THRESH_MIN on loss of lock.
//     undefined : thresh is fixed at THRESH_MIN.
//
// Ports
//   clk_correlator  sample clock (posedge)
//   rst_n           asynchronous active-low reset
//   corr_valid      ref_corr/orth_corr carry a new sample
//   ref_corr        signed reference-code correlation
//   orth_corr       signed orthogonal-code correlation
//   bit_out         decided bit (1 = reference won), held between strobes
//   bit_valid       one-cycle strobe qualifying bit_out/peak_mag
//   locked          symbol timing acquired
//   peak_mag        |metric| of the last decided symbol's peak
module bit_decision #(
  parameter int unsigned SYMBOL_LEN = 60,
  parameter logic [7:0]  THRESH_MIN = 8'd20,
  parameter int unsigned LOSS_LIMIT = 3
) (
  input  logic              clk_correlator,
  input  logic              rst_n,
  input  logic              corr_valid,
  input  logic signed [7:0] ref_corr,
  input  logic signed [7:0] orth_corr,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              locked,
  output logic [7:0]        peak_mag
);

  localparam int unsigned HALF = SYMBOL_LEN / 2;
  localparam int unsigned PH_W = $clog2(SYMBOL_LEN);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SYMBOL_LEN - 1);
  localparam logic [PH_W-1:0] PH_HALF  = PH_W'(HALF);
  localparam logic [PH_W-1:0] PH_SEED  = PH_W'(HALF + 1);
  localparam logic [PH_W-1:0] PH_EARLY = PH_W'(HALF - 1);
  localparam logic [PH_W-1:0] PH_LATE  = PH_W'(HALF + 1);
  localparam logic [2:0]      MISS_LAST = 3'(LOSS_LIMIT - 1);

  typedef enum logic {SEARCH, TRACK} state_t;

  state_t             state;
  logic [PH_W-1:0]    ph;
  logic [PH_W-1:0]    peak_idx;
  logic [7:0]         win_max;
  logic               win_sign;
  logic               hold_ext;
  logic [2:0]         miss_cnt;
  logic [7:0]         thresh;

  logic signed [8:0]  metric;
  logic [8:0]         metric_neg;
  logic [7:0]         mag;
  logic               mag_upd;
  logic [7:0]         cur_max;
  logic               cur_sign;
  logic [PH_W-1:0]    cur_idx;

  assign metric     = {ref_corr[7], ref_corr} - {orth_corr[7], orth_corr};
  assign metric_neg = -metric;
  assign mag        = metric[8] ? metric_neg[7:0] : metric[7:0];

  // Window state including the current sample, so a peak on the last
  // sample of a window is seen by that window's evaluation.
  always_comb begin
    mag_upd  = (mag > win_max);
    cur_max  = mag_upd ? mag : win_max;
    cur_sign = mag_upd ? ~metric[8] : win_sign;
    cur_idx  = mag_upd ? ph : peak_idx;
  end

`ifndef BIT_DECISION_ADAPTIVE_THRESH_EN
  assign thresh = THRESH_MIN;
`else
  logic [7:0] half_max;
  assign half_max = {1'b0, cur_max[7:1]};
`endif

  always_ff @(posedge clk_correlator or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      ph        <= '0;
      peak_idx  <= PH_HALF;
      win_max   <= '0;
      win_sign  <= 1'b0;
      hold_ext  <= 1'b0;
      miss_cnt  <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      locked    <= 1'b0;
      peak_mag  <= '0;
`ifdef BIT_DECISION_ADAPTIVE_THRESH_EN
      thresh    <= THRESH_MIN;
`endif
    end else begin
      bit_valid <= 1'b0;
      if (corr_valid) begin
        unique case (state)
          SEARCH: begin
            if (mag >= thresh) begin
              // The crossing sample occupies window position HALF, so the
              // next sample lands at HALF+1.
              state    <= TRACK;
              locked   <= 1'b1;
              win_max  <= mag;
              win_sign <= ~metric[8];
              peak_idx <= PH_HALF;
              ph       <= PH_SEED;
              hold_ext <= 1'b0;
            end
          end
          TRACK: begin
            win_max  <= cur_max;
            win_sign <= cur_sign;
            peak_idx <= cur_idx;
            if (ph == PH_LAST) begin
              win_max  <= '0;
              win_sign <= 1'b0;
              peak_idx <= PH_HALF;
              hold_ext <= 1'b0;
              ph       <= '0;
              if (cur_max >= thresh) begin
                bit_valid <= 1'b1;
                bit_out   <= cur_sign;
                peak_mag  <= cur_max;
                miss_cnt  <= '0;
                if (cur_idx < PH_EARLY) begin
                  ph <= PH_W'(1);
                end else if (cur_idx > PH_LATE) begin
                  // Late peak: phase 0 is repeated once to stretch the window.
                  hold_ext <= 1'b1;
                end
`ifdef BIT_DECISION_ADAPTIVE_THRESH_EN
                thresh <= (half_max > THRESH_MIN) ? half_max : THRESH_MIN;
`endif
              end else if (miss_cnt == MISS_LAST) begin
                state    <= SEARCH;
                locked   <= 1'b0;
                miss_cnt <= '0;
`ifdef BIT_DECISION_ADAPTIVE_THRESH_EN
                thresh   <= THRESH_MIN;
`endif
              end else begin
                miss_cnt <= miss_cnt + 3'd1;
              end
            end else if (hold_ext) begin
              hold_ext <= 1'b0;
            end else begin
              ph <= ph + 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bit_decision.sv
module tb_bit_decision;

  localparam int unsigned SYMBOL_LEN = 60;
  localparam logic [7:0]  THRESH_MIN = 8'd20;
  localparam int unsigned LOSS_LIMIT = 3;
  localparam int          HALF       = SYMBOL_LEN / 2;

  logic              clk_correlator = 1'b0;
  logic              rst_n = 1'b1;
  logic              corr_valid = 1'b0;
  logic signed [7:0] ref_corr = '0;
  logic signed [7:0] orth_corr = '0;
  logic              bit_out;
  logic              bit_valid;
  logic              locked;
  logic [7:0]        peak_mag;

  bit_decision #(
    .SYMBOL_LEN(SYMBOL_LEN),
    .THRESH_MIN(THRESH_MIN),
    .LOSS_LIMIT(LOSS_LIMIT)
  ) dut (
    .clk_correlator(clk_correlator),
    .rst_n(rst_n),
    .corr_valid(corr_valid),
    .ref_corr(ref_corr),
    .orth_corr(orth_corr),
    .bit_out(bit_out),
    .bit_valid(bit_valid),
    .locked(locked),
    .peak_mag(peak_mag)
  );

  always #5 clk_correlator = ~clk_correlator;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int st_cyc[$];
  int st_bit[$];
  int st_mag[$];

  always @(posedge clk_correlator) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: each window is a list of samples; the decision takes the
  // earliest maximum of the list and maps its list index to a symbol phase.
  bit m_locked = 0, m_bv = 0, m_bit = 0;
  int m_peak = 0, m_miss = 0, m_start = 0, m_len = 0, m_thresh = THRESH_MIN;
  bit m_ext = 0;
  int wmag[$];
  bit wsgn[$];
  int m_met, m_mg, m_best, m_idx, m_pos;

  always @(posedge clk_correlator or negedge rst_n) begin
    if (!rst_n) begin
      m_locked = 0; m_bv = 0; m_bit = 0; m_peak = 0; m_miss = 0;
      m_start = 0; m_len = 0; m_ext = 0; m_thresh = THRESH_MIN;
      wmag.delete(); wsgn.delete();
    end else begin
      m_bv = 0;
      if (corr_valid) begin
        m_met = int'(ref_corr) - int'(orth_corr);
        m_mg  = (m_met < 0) ? -m_met : m_met;
        if (!m_locked) begin
          if (m_mg >= m_thresh) begin
            m_locked = 1;
            wmag = '{m_mg};
            wsgn = '{m_met >= 0};
            m_start = HALF; m_len = SYMBOL_LEN - HALF; m_ext = 0;
          end
        end else begin
          wmag.push_back(m_mg);
          wsgn.push_back(m_met >= 0);
          if (wmag.size() == m_len) begin
            m_best = -1; m_idx = 0;
            for (int i = 0; i < wmag.size(); i++)
              if (wmag[i] > m_best) begin m_best = wmag[i]; m_idx = i; end
            m_pos = m_ext ? ((m_idx == 0) ? 0 : m_idx - 1) : m_start + m_idx;
            if (m_best >= m_thresh) begin
              m_bv = 1; m_bit = wsgn[m_idx]; m_peak = m_best; m_miss = 0;
              if (m_pos < HALF - 1)      begin m_start = 1; m_len = SYMBOL_LEN - 1; m_ext = 0; end
              else if (m_pos > HALF + 1) begin m_start = 0; m_len = SYMBOL_LEN + 1; m_ext = 1; end
              else                       begin m_start = 0; m_len = SYMBOL_LEN;     m_ext = 0; end
`ifdef BIT_DECISION_ADAPTIVE_THRESH_EN
              m_thresh = (m_best / 2 > THRESH_MIN) ? m_best / 2 : THRESH_MIN;
`endif
            end else begin
              m_miss++;
              m_start = 0; m_len = SYMBOL_LEN; m_ext = 0;
              if (m_miss == LOSS_LIMIT) begin
                m_locked = 0; m_miss = 0; m_thresh = THRESH_MIN;
              end
            end
            wmag.delete(); wsgn.delete();
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, plus strobe log.
  always @(negedge clk_correlator) begin
    chk("bit_valid", int'(bit_valid), int'(m_bv));
    chk("locked",    int'(locked),    int'(m_locked));
    chk("bit_out",   int'(bit_out),   int'(m_bit));
    chk("peak_mag",  int'(peak_mag),  m_peak);
    if (bit_valid) begin
      st_cyc.push_back(cyc);
      st_bit.push_back(int'(bit_out));
      st_mag.push_back(int'(peak_mag));
    end
  end

  task automatic send(input int r, input int o);
    @(negedge clk_correlator);
    corr_valid = 1'b1;
    ref_corr   = 8'(r);
    orth_corr  = 8'(o);
  endtask

  task automatic send_gap();
    @(negedge clk_correlator);
    corr_valid = 1'b0;
    ref_corr   = 8'sd100;
    orth_corr  = 8'sd0;
  endtask

  // n samples, peak (r,o) at index p, optional invalid gap before index 10.
  task automatic symbol(input int n, input int p, input int r, input int o, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && i == 10) repeat (gap) send_gap();
      if (i == p) send(r, o);
      else send(0, 0);
    end
  endtask

  int lock_cyc = 0;
  int exp_iv[12] = '{60, 60, 60, 59, 60, 61, 60, 60, 60, 67, 60, 60};
`ifdef BIT_DECISION_ADAPTIVE_THRESH_EN
  localparam int EXP_STROBES = 13;
  localparam int EXP_LAST_PEAK = 100;
`else
  localparam int EXP_STROBES = 14;
  localparam int EXP_LAST_PEAK = 45;
`endif

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk_correlator);
    chk("reset_locked", int'(locked), 0);
    chk("reset_peak", int'(peak_mag), 0);
    rst_n = 1'b1;

    // Quiet input: never locks.
    for (int i = 0; i < 200; i++) send(0, 0);
    @(posedge clk_correlator); #1;
    chk("idle_locked", int'(locked), 0);
    chk("idle_strobes", st_cyc.size(), 0);

    // Acquisition on metric 50.
    send(40, -10);
    @(posedge clk_correlator); #1;
    chk("acq_locked", int'(locked), 1);
    lock_cyc = cyc;
    for (int i = 0; i < SYMBOL_LEN - HALF - 1; i++) send(0, 0);

    symbol(60, 30, 50, 0, 0);
    symbol(60, 30, 50, 0, 0);
    symbol(60, 27, 50, 0, 0);   // early
    symbol(59, 29, 50, 0, 0);   // shortened window, peak at phase 30
    symbol(60, 33, 50, 0, 0);   // late
    symbol(61, 31, 50, 0, 0);   // stretched window, peak at phase 30
    symbol(60, 29, 50, 0, 0);
    symbol(60, 31, 50, 0, 0);
    symbol(60, 30, -30, 30, 0); // orthogonal wins
    symbol(60, 30, 50, 0, 7);   // gap of 7 invalid cycles
    symbol(60, 30, 100, 0, 0);
    symbol(60, 30, 100, 0, 0);
    symbol(60, 30, 45, 0, 0);   // miss only with adaptive threshold
    for (int k = 0; k < 3; k++) symbol(60, 30, 0, 0, 0);
    @(posedge clk_correlator); #1;
    chk("loss_locked", int'(locked), 0);

    chk("strobe_count", st_cyc.size(), EXP_STROBES);
    if (st_cyc.size() >= 13) begin
      chk("first_latency", st_cyc[0] - lock_cyc, SYMBOL_LEN - HALF - 1);
      chk("first_bit", st_bit[0], 1);
      chk("first_mag", st_mag[0], 50);
      for (int i = 1; i <= 12; i++) chk("interval", st_cyc[i] - st_cyc[i-1], exp_iv[i-1]);
      chk("neg_bit", st_bit[9], 0);
      chk("neg_mag", st_mag[9], 60);
      chk("big_mag", st_mag[11], 100);
    end

    // Re-acquire, then reset mid-window.
    for (int i = 0; i < 5; i++) send(0, 0);
    send(40, -10);
    @(posedge clk_correlator); #1;
    chk("reacq_locked", int'(locked), 1);
    for (int i = 0; i < 10; i++) send(0, 0);
    @(negedge clk_correlator); #2;
    chk("pre_rst_peak", int'(peak_mag), EXP_LAST_PEAK);
    rst_n = 1'b0;
    #1;
    chk("rst_locked", int'(locked), 0);
    chk("rst_peak", int'(peak_mag), 0);
    chk("rst_valid", int'(bit_valid), 0);
    corr_valid = 1'b0;
    repeat (3) @(negedge clk_correlator);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_correlator);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
